// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-side program counter.
//   PC_ADDR_W     default address width
//   PC_RESET_VEC  default reset vector
//   MAX_ADDR_W    widest address the align helper handles
//   pc_src_e      next-PC source selected by the priority mux
//   align()       clears the low address bits for a given instruction size
package pc_pkg;

  localparam int unsigned PC_ADDR_W    = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned MAX_ADDR_W   = 64;

  // Listed highest priority first.
  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_HOLD,
    SRC_BR,
    SRC_RET,
    SRC_SEQ
  } pc_src_e;

  // insn_bytes is a power of two, so (insn_bytes - 1) is the low-bit mask.
  function automatic logic [MAX_ADDR_W-1:0] align(input logic [MAX_ADDR_W-1:0] addr,
                                                  input int unsigned           insn_bytes);
    logic [MAX_ADDR_W-1:0] mask;
    mask = MAX_ADDR_W'(insn_bytes) - MAX_ADDR_W'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: request/response bundle between the branch/exception
// logic (master) and the fetch PC (slave).
//   stall, exc_valid/exc_vector, br_valid/br_target/br_call, ret_valid : requests
//   pc_o, pc_seq_o                                                     : fetch address
//   ras_empty, ras_full, ras_err                                       : RAS status
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = pc_pkg::PC_ADDR_W
);

  logic              stall;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_vector;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              br_call;
  logic              ret_valid;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] pc_seq_o;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, exc_valid, exc_vector, br_valid, br_target, br_call, ret_valid,
    input  pc_o, pc_seq_o, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, exc_valid, exc_vector, br_valid, br_target, br_call, ret_valid,
    output pc_o, pc_seq_o, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack.
//   clk, reset            clock, asynchronous active-high reset
//   push, push_data       write a new top entry (overwrites the oldest when full)
//   pop                   discard the top entry (no effect when empty)
//   flush                 empty the stack
//   top_data              current top entry
//   empty, full           occupancy flags from the registered count
//   overflow, underflow   push-while-full / pop-while-empty this cycle
module return_addr_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_inc;
  logic [CNT_W-1:0]  cnt_q;

  // Depth is a power of two, so the pointer wraps naturally.
  assign ptr_inc   = ptr_q + PTR_W'(1);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign overflow  = push && full;
  assign underflow = pop && empty;
  assign top_data  = mem[ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      // When full the write lands on the oldest entry; count saturates.
      ptr_q <= ptr_inc;
      if (!full) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; the count alone decides which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-side program counter with prioritised redirects and
// a return-address stack for call/return prediction.
//   clk, reset   clock, asynchronous active-high reset
//   bus (slave)  stall, exc_valid/exc_vector, br_valid/br_target/br_call,
//                ret_valid in; pc_o (registered), pc_seq_o (pc_o + INSN_BYTES),
//                ras_empty, ras_full, ras_err (sticky) out
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(PC_RESET_VEC),
  parameter int unsigned       INSN_BYTES = 4,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  pc_fetch_unit_if.slave   bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_top;
  pc_src_e           src;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_flush;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_unf;
  logic              err_q;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return ADDR_W'(align(MAX_ADDR_W'(addr), INSN_BYTES));
  endfunction

  // Modulo 2^ADDR_W: the carry out is simply dropped.
  assign pc_seq = pc_q + ADDR_W'(INSN_BYTES);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    src = SRC_SEQ;
    if (bus.exc_valid)     src = SRC_EXC;
    else if (bus.stall)    src = SRC_HOLD;
    else if (bus.br_valid) src = SRC_BR;
    else if (bus.ret_valid) src = SRC_RET;
  end

  // Requests masked by stall never reach the stack.
  assign ras_push  = (src == SRC_BR) && bus.br_call;
  assign ras_pop   = (src == SRC_RET);
  assign ras_flush = (src == SRC_EXC);

  always_comb begin
    pc_next = pc_seq;
    case (src)
      SRC_EXC:  pc_next = align_addr(bus.exc_vector);
      SRC_HOLD: pc_next = pc_q;
      SRC_BR:   pc_next = align_addr(bus.br_target);
      // An empty stack falls through to the sequential address.
      SRC_RET:  pc_next = ras_empty ? pc_seq : align_addr(ras_top);
      default:  pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_next;
  end

  // Exception takes priority, so an error raised by the same cycle's
  // request cannot coexist with the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 err_q <= 1'b0;
    else if (bus.exc_valid)    err_q <= 1'b0;
    else if (ras_ovf || ras_unf) err_q <= 1'b1;
  end

  return_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (ras_flush),
    .push_data (pc_seq),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  assign bus.pc_o      = pc_q;
  assign bus.pc_seq_o  = pc_seq;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven bench for pc_fetch_unit (RESET_VEC 0x100,
// 4-byte instructions, 4-entry RAS) with a scoreboard queue of expectations.
module tb_pc_fetch_unit;

  logic clk;
  logic reset;

  pc_fetch_unit_if #(.ADDR_W(32)) bus ();

  pc_fetch_unit #(
    .ADDR_W     (32),
    .RESET_VEC  (32'h0000_0100),
    .INSN_BYTES (4),
    .RAS_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        exc;
    logic [31:0] exc_vec;
    logic        br;
    logic [31:0] br_tgt;
    logic        call;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[34];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic s, input logic e, input logic [31:0] ev,
                              input logic b, input logic [31:0] bt, input logic c,
                              input logic r, input logic [31:0] pc, input logic em,
                              input logic fu, input logic er);
    vec_t v;
    v.stall = s;  v.exc = e;  v.exc_vec = ev; v.br = b; v.br_tgt = bt;
    v.call = c;   v.ret = r;  v.exp_pc = pc;  v.exp_empty = em;
    v.exp_full = fu; v.exp_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.stall      = v.stall;
    bus.exc_valid  = v.exc;
    bus.exc_vector = v.exc_vec;
    bus.br_valid   = v.br;
    bus.br_target  = v.br_tgt;
    bus.br_call    = v.call;
    bus.ret_valid  = v.ret;
  endtask

  // Drive one cycle of requests, queue the expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    e.pc = v.exp_pc; e.empty = v.exp_empty; e.full = v.exp_full; e.err = v.exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, " pc_o"},      bus.pc_o, e.pc);
      check({tag, " pc_seq_o"},  bus.pc_seq_o, e.pc + 32'd4);
      check({tag, " ras_empty"}, 32'(bus.ras_empty), 32'(e.empty));
      check({tag, " ras_full"},  32'(bus.ras_full), 32'(e.full));
      check({tag, " ras_err"},   32'(bus.ras_err), 32'(e.err));
    end
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           stall exc vec     br  target        call ret  exp_pc        empty full err
    vecs[0]  = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_0104, 1, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_0108, 1, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_010C, 1, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,  1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_0000, 1, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,  1, 32'h0000_0203, 0, 0, 32'h0000_0200, 1, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,  1, 32'h0000_0040, 0, 0, 32'h0000_0040, 1, 0, 0);
    vecs[7]  = mk(0, 0, 32'h0,  1, 32'h0000_0800, 1, 0, 32'h0000_0800, 0, 0, 0);
    vecs[8]  = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_0804, 0, 0, 0);
    vecs[9]  = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_0808, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_0044, 1, 0, 0);
    vecs[11] = mk(1, 0, 32'h0,  1, 32'h0000_0500, 0, 0, 32'h0000_0044, 1, 0, 0);
    vecs[12] = mk(1, 0, 32'h0,  1, 32'h0000_0500, 1, 0, 32'h0000_0044, 1, 0, 0);
    vecs[13] = mk(0, 0, 32'h0,  1, 32'h0000_0300, 0, 1, 32'h0000_0300, 1, 0, 0);
    vecs[14] = mk(0, 0, 32'h0,  0, 32'h0000_0900, 1, 0, 32'h0000_0304, 1, 0, 0);
    vecs[15] = mk(0, 0, 32'h0,  1, 32'h0000_1000, 1, 0, 32'h0000_1000, 0, 0, 0);
    vecs[16] = mk(0, 0, 32'h0,  1, 32'h0000_2000, 1, 0, 32'h0000_2000, 0, 0, 0);
    vecs[17] = mk(0, 0, 32'h0,  1, 32'h0000_3000, 1, 0, 32'h0000_3000, 0, 0, 0);
    vecs[18] = mk(0, 0, 32'h0,  1, 32'h0000_4000, 1, 0, 32'h0000_4000, 0, 1, 0);
    vecs[19] = mk(0, 0, 32'h0,  1, 32'h0000_5000, 1, 0, 32'h0000_5000, 0, 1, 1);
    vecs[20] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_4004, 0, 0, 1);
    vecs[21] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_3004, 0, 0, 1);
    vecs[22] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_2004, 0, 0, 1);
    vecs[23] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_1004, 1, 0, 1);
    vecs[24] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_1008, 1, 0, 1);
    vecs[25] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_100C, 1, 0, 1);
    vecs[26] = mk(0, 0, 32'h0,  1, 32'h0000_0600, 1, 0, 32'h0000_0600, 0, 0, 1);
    vecs[27] = mk(1, 1, 32'h18, 1, 32'h0000_0900, 1, 0, 32'h0000_0018, 1, 0, 0);
    vecs[28] = mk(0, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_001C, 1, 0, 0);
    vecs[29] = mk(1, 0, 32'h0,  0, 32'h0,         0, 0, 32'h0000_001C, 1, 0, 0);
    vecs[30] = mk(0, 1, 32'h23, 0, 32'h0,         0, 0, 32'h0000_0020, 1, 0, 0);
    vecs[31] = mk(0, 0, 32'h0,  1, 32'h0000_0700, 1, 0, 32'h0000_0700, 0, 0, 0);
    vecs[32] = mk(1, 1, 32'h0,  0, 32'h0,         0, 0, 32'h0000_0000, 1, 0, 0);
    vecs[33] = mk(0, 0, 32'h0,  0, 32'h0,         0, 1, 32'h0000_0004, 1, 0, 1);

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset pc_o",      bus.pc_o, 32'h0000_0100);
    check("reset pc_seq_o",  bus.pc_seq_o, 32'h0000_0104);
    check("reset ras_empty", 32'(bus.ras_empty), 32'd1);
    check("reset ras_full",  32'(bus.ras_full), 32'd0);
    check("reset ras_err",   32'(bus.ras_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 34; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Call burst, then asynchronous reset between clock edges.
    apply(mk(0, 0, 32'h0, 1, 32'h0000_0900, 1, 0, 32'h0000_0900, 0, 0, 1), "burst0");
    apply(mk(0, 0, 32'h0, 1, 32'h0000_0A00, 1, 0, 32'h0000_0A00, 0, 0, 1), "burst1");
    drive(mk(0, 0, 32'h0, 1, 32'h0000_0B00, 1, 0, 32'h0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async pc_o",      bus.pc_o, 32'h0000_0100);
    check("async ras_empty", 32'(bus.ras_empty), 32'd1);
    check("async ras_full",  32'(bus.ras_full), 32'd0);
    check("async ras_err",   32'(bus.ras_err), 32'd0);
    @(posedge clk);
    #1;
    check("reset held pc_o", bus.pc_o, 32'h0000_0100);
    reset = 1'b0;
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0104, 1, 0, 0), "post_reset0");
    // Empty stack after reset: return falls through and flags underflow.
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0000_0108, 1, 0, 1), "post_reset1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Next-generation fetch-side program counter for the ARM32 core. It generalises the plain loadable PC in several ways:
- parametrised address width and reset vector;
- auto-increment by instruction size;
- prioritised redirect sources (exception, branch, return);
- a small circular return-address stack (RAS) for call/return prediction.

It sits between the branch/exception logic and instruction memory, and drives the fetch address every cycle.

Parameters:
ADDR_W, 32, width of PC and all address ports.
RESET_VEC, 0, PC value after reset (ADDR_W bits).
INSN_BYTES, 4, sequential increment; power of 2, 1..8.
RAS_DEPTH, 4, return-address stack entries; power of 2, 2..16.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold PC (pipeline back-pressure).
exc_valid  in  1  exception redirect request.
exc_vector  in  ADDR_W  exception handler address.
br_valid  in  1  taken branch/jump redirect.
br_target  in  ADDR_W  branch destination.
br_call  in  1  qualifies br_valid as a call (BL): push return address.
ret_valid  in  1  return request: pop RAS and redirect to popped address.
pc_o  out  ADDR_W  current fetch address (registered).
pc_seq_o  out  ADDR_W  pc_o + INSN_BYTES (combinational, modulo 2^ADDR_W).
ras_empty  out  1  RAS holds 0 entries.
ras_full  out  1  RAS holds RAS_DEPTH entries.
ras_err  out  1  sticky: set by overflow or underflow, cleared by reset or exc_valid.

Behaviour:
- Reset: clk and reset are as already decided (asynchronous, active-high reset; clock clk). While reset is asserted: pc_o = RESET_VEC, RAS count = 0, RAS pointer = 0, ras_err = 0. On reset: ras_empty = 1, ras_full = 0.
- Registered update: pc_o updates on the rising edge of clk, one cycle latency from request to new pc_o. pc_seq_o follows pc_o combinationally.
- Alignment: all redirect targets are loaded with bits [log2(INSN_BYTES)-1:0] forced to 0.
- Next-PC priority, highest first:
  1. exc_valid -> exc_vector. Wins over stall. Clears RAS (count = 0) and clears ras_err.
  2. stall -> pc_o held. br_valid, br_call and ret_valid are ignored with no RAS change; upstream must hold requests until stall drops.
  3. br_valid -> br_target. If br_call = 1, push pc_seq_o.
  4. ret_valid -> popped RAS top; count decrements.
  5. otherwise -> pc_seq_o. Wraps modulo 2^ADDR_W: all-ones-aligned + INSN_BYTES = 0.
- br_valid and ret_valid in the same cycle: branch wins; ret is ignored with no pop.
- br_call without br_valid: ignored.
- RAS organisation: circular buffer of RAS_DEPTH x ADDR_W with a top pointer and a count of 0..RAS_DEPTH.
  - Push: pointer += 1 (wrapping), write entry, count = min(count + 1, RAS_DEPTH).
  - Pop: read top, pointer -= 1 (wrapping), count -= 1.
- RAS overflow: push while full overwrites the oldest entry; count stays RAS_DEPTH; ras_err set.
- RAS underflow: ret_valid while empty redirects to pc_seq_o (fall-through); no pointer change; ras_err set.
- ras_empty = (count == 0); ras_full = (count == RAS_DEPTH). Both are combinational from registered count.
- Reset mid-operation: asynchronous return to reset state regardless of pending requests. The first post-reset fetch is RESET_VEC.
- No combinational path from any input to pc_o.

Decomposition:
- Shared package pc_pkg:
  - ADDR_W default;
  - RESET_VEC default;
  - next-PC source enum: SRC_EXC, SRC_HOLD, SRC_BR, SRC_RET, SRC_SEQ;
  - align function (clears low bits).
- One sub-module, return_addr_stack:
  - parametrised ADDR_W, RAS_DEPTH;
  - push, pop, push_data, top_data, empty, full, overflow, underflow, flush.
- pc_fetch_unit holds the PC register, priority mux and ras_err.

Test Plan:
- Reset with RESET_VEC = 0x100, then 3 idle cycles -> pc_o 0x100, 0x104, 0x108, 0x10C; ras_empty = 1.
- Wrap: br_target = 0xFFFFFFFC, next cycle idle -> pc_o 0xFFFFFFFC then 0x00000000. br_target 0x203 -> pc_o 0x200.
- Call/return: at pc 0x40, br_valid + br_call, target 0x800 -> pc 0x800; idle to 0x808; ret_valid -> pc 0x44; ras_empty = 1; ras_err = 0.
- Overflow/underflow, RAS_DEPTH = 4:
  - 5 calls from pcs A..E -> ras_full = 1, ras_err = 1; 4 returns yield E+4, D+4, C+4, B+4.
  - A 5th return -> fall-through to pc_seq_o, ras_empty = 1.
- Priority: exc_valid + br_valid + stall together, exc_vector 0x18 -> pc 0x18, RAS flushed, ras_err cleared. stall + br_valid alone -> pc held, no push.
- Async reset asserted mid-cycle during a call burst -> pc_o = RESET_VEC immediately (before next edge), count = 0.
